snake_game_ctrl: RTL

Game-flow controller for the LCD snake game. It sequences the game states (idle, play, pause, over) and generates the move tick that advances the snake datapath. It arbitrates direction requests so that at most one direction change commits per step, and reversals are rejected. It also detects wall collisions, keeps the score, and derives a speed level that shortens the tick period. It sits between the key-pulse inputs and the snake/food datapath, which consumes `step`, `clr` and `dir` and returns the head position and the eat pulse.

---
 rtl/snake_game_ctrl_if.sv | 34 +++
 rtl/snake_game_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if
//   Bundle between the snake game-flow controller and its environment
//   (key-pulse sources and the snake/food datapath).
//   Key inputs : start, pause, up, down, left, right (one-cycle pulses)
//   Datapath   : head_x, head_y (current head), eat (food-eaten pulse)
//   Controller : state, step, clr, dir, score, level (all registered)
//   master = key/datapath side, slave = controller side.
interface snake_game_ctrl_if;
  logic       start;
  logic       pause;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [8:0] head_x;
  logic [8:0] head_y;
  logic       eat;
  logic [1:0] state;
  logic       step;
  logic       clr;
  logic [1:0] dir;
  logic [7:0] score;
  logic [2:0] level;

  modport master (
    output start, pause, up, down, left, right, head_x, head_y, eat,
    input  state, step, clr, dir, score, level
  );

  modport slave (
    input  start, pause, up, down, left, right, head_x, head_y, eat,
    output state, step, clr, dir, score, level
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Game-flow controller for the LCD snake game. Sequences IDLE/PLAY/PAUSE/
//   OVER, generates the move tick (period shrinks with level), arbitrates
//   direction requests (one commit per step, reversals rejected), detects
//   wall collisions and keeps a saturating score plus derived speed level.
//   Ports: clk, rst (sync, active-high), bus (snake_game_ctrl_if.slave).
module snake_game_ctrl #(
  parameter int unsigned TICK_BASE = 25_000_000,
  parameter int unsigned TICK_STEP = 2_500_000,
  parameter int unsigned MAX_LEVEL = 7,
  parameter int unsigned CELL      = 25,
  parameter int unsigned X_MAX     = 455,
  parameter int unsigned Y_MAX     = 247
) (
  input  logic               clk,
  input  logic               rst,
  snake_game_ctrl_if.slave   bus
);

  localparam int unsigned CW = $clog2(TICK_BASE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [7:0]    score_q, score_d;
  logic [2:0]    level_q, level_d;
  logic          step_q, step_d;
  logic          clr_q, clr_d;

  logic [31:0]   per_m1;
  logic          tick;
  logic          req_vld;
  logic [1:0]    req_dir;
  logic          hit;

  // Tick when count reaches period-1; >= tolerates a period that shrinks mid-count.
  assign per_m1 = TICK_BASE - 32'(level_q) * TICK_STEP - 32'd1;
  assign tick   = (32'(cnt_q) >= per_m1);

  // Fixed-priority request select: up > down > left > right.
  always_comb begin
    req_vld = 1'b1;
    req_dir = 2'b00;
    if (bus.up)         req_dir = 2'b00;
    else if (bus.down)  req_dir = 2'b01;
    else if (bus.left)  req_dir = 2'b10;
    else if (bus.right) req_dir = 2'b11;
    else                req_vld = 1'b0;
  end

  // Wall test for the next head position in the pending direction (10-bit sums).
  always_comb begin
    hit = 1'b0;
    case (pend_q)
      2'b00:   hit = (bus.head_y < 9'(CELL));
      2'b01:   hit = (({1'b0, bus.head_y} + 10'(CELL)) > 10'(Y_MAX));
      2'b10:   hit = (bus.head_x < 9'(CELL));
      default: hit = (({1'b0, bus.head_x} + 10'(CELL)) > 10'(X_MAX));
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    score_d = score_q;
    step_d  = 1'b0;
    clr_d   = 1'b0;
    level_d = (score_q[7:2] > 6'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : score_q[4:2];
    case (state_q)
      IDLE, OVER: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = PLAY;
          clr_d   = 1'b1;
          score_d = '0;
          level_d = '0;
          dir_d   = '0;
          pend_d  = '0;
        end
      end
      PLAY: begin
        if (req_vld && (req_dir != {dir_q[1], ~dir_q[0]}))
          pend_d = req_dir;
        if (bus.eat && (score_q != '1))
          score_d = score_q + 8'd1;
        // A pause takes priority over a due tick; the held count ticks on resume.
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          cnt_d = '0;
          if (hit) begin
            state_d = OVER;
          end else begin
            dir_d  = pend_q;
            step_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAUSE: begin
        if (bus.pause)
          state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dir_q   <= '0;
      pend_q  <= '0;
      score_q <= '0;
      level_q <= '0;
      step_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      level_q <= level_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.state = state_q;
  assign bus.step  = step_q;
  assign bus.clr   = clr_q;
  assign bus.dir   = dir_q;
  assign bus.score = score_q;
  assign bus.level = level_q;

endmodule
